// File: rtl/mem_pkg.sv
// Shared definitions for the memory-to-memory copy DMA.
//   DEFAULT_*   : default widths/sizes used by the DMA and its address generators
//   WORD_BYTES  : bytes per memory word; addresses step by this amount
//   dma_state_t : copy engine state encoding
package mem_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_MEM_SIZE   = 1024;
  localparam int unsigned WORD_BYTES         = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFirst,   // read word 0 only
    StStream,  // read word i+1, write word i
    StLast,    // write final word only
    StDone
  } dma_state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Byte-address generator: loads a base address and steps it by one word.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (clears to 0)
//   load       : capture load_addr (has priority over inc)
//   load_addr  : base byte address
//   inc        : advance by WORD_BYTES
//   addr       : current byte address
module mem_copy_addr_gen
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= load_addr;
    end else if (inc) begin
      addr_q <= addr_q + ADDR_WIDTH'(WORD_BYTES);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Word-granular memory copy engine driving one DataMemory read port and one
// write port. Streams one word per cycle after a single cycle of read lead-in.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   start, src_addr,
//   dst_addr, len         : copy command, accepted only while idle
//   abort                 : cancel an active copy (write suppressed that cycle)
//   busy, done, err       : status; done is a one-cycle pulse qualified by err
//   words_done            : words written for the current/last command
//   mem_we, mem_addr,
//   mem_wdata             : DataMemory write port
//   mem_raddr, mem_rdata  : DataMemory read port (rdata one cycle after raddr)
module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned AlignBits = $clog2(WORD_BYTES);

  dma_state_t           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [LEN_WIDTH-1:0] words_q;
  logic [LEN_WIDTH-1:0] len_q;

  logic [ADDR_WIDTH-1:0] src_cur;
  logic [ADDR_WIDTH-1:0] dst_cur;
  logic                  accept;
  logic                  read_en;
  logic                  write_en;

  // Range check is done one bit wider than the address so that the end-of-range
  // sum itself cannot wrap.
  logic [ADDR_WIDTH:0] src_end;
  logic [ADDR_WIDTH:0] dst_end;
  logic [ADDR_WIDTH:0] mem_limit;
  logic                reject;

  assign src_end   = {1'b0, src_addr >> AlignBits} + (ADDR_WIDTH + 1)'(len);
  assign dst_end   = {1'b0, dst_addr >> AlignBits} + (ADDR_WIDTH + 1)'(len);
  assign mem_limit = (ADDR_WIDTH + 1)'(MEM_SIZE);
  assign reject    = (src_addr[AlignBits-1:0] != '0) || (dst_addr[AlignBits-1:0] != '0) ||
                     (src_end > mem_limit) || (dst_end > mem_limit);

  assign accept   = (state_q == StIdle) && start;
  assign read_en  = (state_q == StFirst) || (state_q == StStream);
  // Abort suppresses the write of the cycle it arrives in.
  assign write_en = ((state_q == StStream) || (state_q == StLast)) && !abort;

  mem_copy_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_src_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (src_addr),
    .inc       (read_en),
    .addr      (src_cur)
  );

  mem_copy_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dst_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (dst_addr),
    .inc       (write_en),
    .addr      (dst_cur)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      len_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= len;
            words_q <= '0;
            err_q   <= 1'b0;
            if (reject) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFirst;
              busy_q  <= 1'b1;
            end
          end
        end
        StFirst: begin
          if (abort) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (len_q == LEN_WIDTH'(1)) begin
            state_q <= StLast;
          end else begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (abort) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            words_q <= words_q + LEN_WIDTH'(1);
            // Word len-2 is being written now; only the final write remains.
            if (words_q == len_q - LEN_WIDTH'(2)) begin
              state_q <= StLast;
            end
          end
        end
        StLast: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            words_q <= words_q + LEN_WIDTH'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (read_en) begin
      mem_raddr = src_cur;
    end
    if (write_en) begin
      mem_we    = 1'b1;
      mem_addr  = dst_cur;
      mem_wdata = mem_rdata;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: an attached DataMemory, a cycle-relative behavioural
// model of each command (latency/abort rules plus a shadow memory) compared
// every cycle, directed scenarios with literal expectations, then random copies.
module tb_mem_copy_dma;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MS = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err, mem_we;
  logic [LW-1:0] words_done;
  logic [AW-1:0] mem_addr, mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] ram     [MS];
  logic [DW-1:0] exp_ram [MS];
  logic          bw_en = 1'b0;
  logic [9:0]    bw_idx = '0;
  logic [DW-1:0] bw_data = '0;

  always #5 clk = ~clk;

  mem_copy_dma #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_SIZE   (MS),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata)
  );

  // DataMemory: synchronous read, write on mem_we; bench back-door for preload.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bw_en) ram[bw_idx] <= bw_data;
    else if (mem_we && mem_addr[AW-1:12] == '0) ram[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= (mem_raddr[AW-1:12] == '0) ? ram[mem_raddr[11:2]] : '0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the command in flight (or last finished); m_have=0 means post-reset.
  bit            chk_en = 1'b0;
  bit            m_have = 1'b0;
  bit            m_act, m_rej;
  int            m_c0, m_end, m_ab, m_len;
  logic [AW-1:0] m_src, m_dst;
  // Observations of the current command, for the directed literal checks.
  int            obs_we, obs_we_first, obs_done_n, obs_done_cnt = 0;
  logic          obs_done_err;

  function automatic bit dut_idle();
    return !m_have || (cyc > m_end);
  endfunction

  initial begin : compare
    int n, e, w, k;
    logic          x_busy, x_done, x_err, x_we, rd_dc;
    logic [LW-1:0] x_words;
    logic [AW-1:0] x_addr, x_raddr;
    logic [DW-1:0] x_wdata;
    forever begin
      @(negedge clk);
      if (bw_en) exp_ram[bw_idx] = bw_data;
      if (chk_en) begin
        n = cyc - m_c0;
        if (m_have && m_act && m_ab == 0 && abort && n >= 1 && n <= m_len + 1) begin
          m_ab  = n;
          m_end = m_c0 + n + 1;
        end
        x_busy = 0; x_done = 0; x_err = 0; x_we = 0; rd_dc = 0;
        x_words = '0; x_addr = '0; x_raddr = '0; x_wdata = '0; k = 0;
        if (m_have) begin
          if (!m_act) begin
            x_done = (n == 1);
            x_err  = m_rej;
          end else begin
            e = m_end - m_c0;
            w = (m_ab == 0) ? m_len : ((m_ab > 2) ? m_ab - 2 : 0);
            x_busy  = (n < e);
            x_done  = (n == e);
            x_err   = (n >= e) && (m_ab != 0);
            x_we    = (n >= 2) && (n <= m_len + 1) && (m_ab == 0 || n < m_ab);
            x_words = LW'((n - 2 < 0) ? 0 : ((n - 2 > w) ? w : n - 2));
            if (x_we) begin
              k       = n - 2;
              x_addr  = m_dst + AW'(4 * k);
              x_wdata = exp_ram[int'(m_src >> 2) + k];
            end
            if (n >= 1 && n <= m_len && n < e) x_raddr = m_src + AW'(4 * (n - 1));
            rd_dc = (n == m_ab);
          end
        end
        chk("busy", busy, x_busy);
        chk("done", done, x_done);
        chk("err", err, x_err);
        chk("words_done", words_done, x_words);
        chk("mem_we", mem_we, x_we);
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wdata);
        if (!rd_dc) chk("mem_raddr", mem_raddr, x_raddr);
        if (mem_we) begin
          if (obs_we == 0) obs_we_first = n;
          obs_we++;
        end
        if (done) begin
          obs_done_n   = n;
          obs_done_err = err;
          obs_done_cnt++;
        end
        if (x_we) exp_ram[int'(m_dst >> 2) + k] = x_wdata;
        if (rst) begin
          m_have = 1'b0;
        end else if (start && dut_idle()) begin
          m_have = 1'b1;
          m_c0   = cyc;
          m_src  = src_addr;
          m_dst  = dst_addr;
          m_len  = int'(len);
          m_ab   = 0;
          m_rej  = (src_addr[1:0] != 0) || (dst_addr[1:0] != 0) ||
                   (longint'(src_addr >> 2) + m_len > MS) ||
                   (longint'(dst_addr >> 2) + m_len > MS);
          m_act  = !m_rej && (m_len > 0);
          m_end  = m_act ? m_c0 + m_len + 2 : m_c0 + 1;
          obs_we = 0; obs_we_first = -1; obs_done_n = -1; obs_done_err = 1'bx;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [DW-1:0] d);
    bw_en = 1'b1; bw_idx = idx[9:0]; bw_data = d;
    tick();
    bw_en = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for the model to report idle; optional random abort/start noise.
  task automatic wait_idle(input int budget, input bit noise);
    for (int i = 0; i < budget; i++) begin
      if (dut_idle()) return;
      if (noise) begin
        abort = ($urandom_range(0, 29) == 0);
        start = ($urandom_range(0, 7) == 0);
      end
      tick();
      abort = 1'b0;
      start = 1'b0;
    end
    chk("idle_timeout", dut_idle(), 1);
  endtask

  initial begin : stim
    logic [AW-1:0] r_s, r_d;
    int            r_l, d0, bad;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_words", words_done, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_raddr", mem_raddr, 0);
    rst = 1'b0;
    for (int i = 0; i < MS; i++) poke(i, $urandom);

    // Basic 4-word copy.
    for (int i = 0; i < 4; i++) poke(32'h40 + i, DW'((i + 1) * 32'h11));
    issue(32'h100, 32'h200, 4);
    wait_idle(20, 0);
    chk("r40_we_count", obs_we, 4);
    chk("r40_first_we_cycle", obs_we_first, 2);
    chk("r40_done_cycle", obs_done_n, 6);
    chk("r40_err", obs_done_err, 0);
    chk("r40_words", words_done, 4);
    for (int i = 0; i < 4; i++) chk("r40_dst_word", ram[32'h80 + i], DW'((i + 1) * 32'h11));

    // Zero length.
    issue(32'h100, 32'h200, 0);
    wait_idle(10, 0);
    chk("r41_done_cycle", obs_done_n, 1);
    chk("r41_err", obs_done_err, 0);
    chk("r41_we_count", obs_we, 0);

    // Single word.
    poke(32'h40, 32'hABCD1234);
    issue(32'h100, 32'h104, 1);
    wait_idle(10, 0);
    chk("r42_we_count", obs_we, 1);
    chk("r42_we_cycle", obs_we_first, 2);
    chk("r42_done_cycle", obs_done_n, 3);
    chk("r42_dst_word", ram[32'h41], 32'hABCD1234);

    // Rejections: misaligned source, destination past the end.
    issue(32'h102, 32'h200, 2);
    wait_idle(10, 0);
    chk("r43a_done_cycle", obs_done_n, 1);
    chk("r43a_err", obs_done_err, 1);
    chk("r43a_we_count", obs_we, 0);
    issue(32'h100, 32'hFFC, 2);
    wait_idle(10, 0);
    chk("r43b_done_cycle", obs_done_n, 1);
    chk("r43b_err", obs_done_err, 1);
    chk("r43b_we_count", obs_we, 0);

    // Abort in cycle 4, with an ignored start in cycle 3.
    issue(32'h000, 32'h400, 8);
    tick();
    tick();
    src_addr = 32'h800; dst_addr = 32'hC00; len = 3; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(20, 0);
    chk("r44_we_count", obs_we, 2);
    chk("r44_done_cycle", obs_done_n, 5);
    chk("r44_err", obs_done_err, 1);
    chk("r44_words", words_done, 2);

    // Reset in cycle 3, then a normal command.
    issue(32'h000, 32'h400, 8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r45_busy", busy, 0);
    chk("r45_we", mem_we, 0);
    chk("r45_words", words_done, 0);
    chk("r45_err", err, 0);
    d0 = obs_done_cnt;
    repeat (12) tick();
    chk("r45_no_done", obs_done_cnt, d0);
    issue(32'h000, 32'h400, 8);
    wait_idle(20, 0);
    chk("r45_done_cycle", obs_done_n, 10);
    chk("r45_err_after", obs_done_err, 0);
    chk("r45_words_after", words_done, 8);

    // Random commands with abort/start noise.
    for (int t = 0; t < 80; t++) begin
      r_l = $urandom_range(0, 12);
      r_s = AW'($urandom_range(0, MS - 1) * 4);
      r_d = AW'($urandom_range(0, MS - 1) * 4);
      if ($urandom_range(0, 9) == 0) r_s = r_s + AW'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) r_d = AW'(32'h1000 - 4 * $urandom_range(0, 3));
      if (r_d > r_s && r_d < r_s + AW'(4 * r_l)) r_d = r_s;
      issue(r_s, r_d, LW'(r_l));
      wait_idle(40, 1);
      repeat ($urandom_range(0, 2)) tick();
    end

    bad = 0;
    for (int i = 0; i < MS; i++) if (ram[i] !== exp_ram[i]) bad++;
    chk("final_ram_words_differing", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
